gcd_requester: RTL and testbench

- Initiator/consumer-side sequencer for the GCD unit (`toplevel`: In_A, In_B, In_ready, Result_taken, Result).
- Buffers operand pairs from a host in a small job FIFO and issues them one at a time to the GCD with the In_ready / Result_taken handshake.
- Captures each GCD result together with its operands into an output register, released through a valid/ack handshake.
- Replaces the hand-driven stimulus logic, so the GCD can run back-to-back jobs autonomously.

---
 rtl/gcd_requester.sv | 151 +++++++++++++++
 tb/tb_gcd_requester.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_requester.sv
// Host-side sequencer for the GCD unit: queues operand pairs, runs them through
// the In_ready/Result_taken handshake one at a time and presents each result on a valid/ack slot.
module gcd_requester #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             Job_wr,
  input  logic [WIDTH-1:0] Job_A,
  input  logic [WIDTH-1:0] Job_B,
  output logic             Job_full,
  output logic             Job_ovf,
  output logic [WIDTH-1:0] Gcd_A,
  output logic [WIDTH-1:0] Gcd_B,
  output logic             Gcd_ready,
  output logic             Gcd_taken,
  input  logic             Gcd_busy,
  input  logic             Gcd_done,
  input  logic [WIDTH-1:0] Gcd_result,
  output logic             Res_valid,
  output logic [WIDTH-1:0] Res_A,
  output logic [WIDTH-1:0] Res_B,
  output logic [WIDTH-1:0] Res_gcd,
  input  logic             Res_ack,
  output logic [CNTW-1:0]  Jobs_done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, TAKE} state_t;

  state_t           state;
  logic [WIDTH-1:0] fifo_a [DEPTH];
  logic [WIDTH-1:0] fifo_b [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             push;
  logic             pop;
  logic             slot_free;
  logic             capture;

  // A result may be captured from WAIT, or straight from ISSUE when the GCD
  // finished without ever showing busy.
  always_comb begin
    push       = Job_wr && !Job_full;
    pop        = (state == IDLE) && (count != '0);
    slot_free  = !Res_valid || Res_ack;
    capture    = Gcd_done && slot_free &&
                 ((state == WAIT) || ((state == ISSUE) && !Gcd_busy));
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (pop && !push) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= Job_A;
      fifo_b[wr_ptr] <= Job_B;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Job_full <= 1'b0;
      Job_ovf  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count    <= count_next;
      Job_full <= (count_next == CW'(DEPTH));
      if (Job_wr && Job_full) begin
        Job_ovf <= 1'b1;
      end
    end
  end

  // The capture block comes after the case so its TAKE transition overrides
  // the ISSUE->WAIT move in the single-cycle-compute case.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      Gcd_A     <= '0;
      Gcd_B     <= '0;
      Gcd_ready <= 1'b0;
      Gcd_taken <= 1'b0;
      Res_valid <= 1'b0;
      Res_A     <= '0;
      Res_B     <= '0;
      Res_gcd   <= '0;
      Jobs_done <= '0;
    end else begin
      if (Res_ack) begin
        Res_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            Gcd_A     <= fifo_a[rd_ptr];
            Gcd_B     <= fifo_b[rd_ptr];
            Gcd_ready <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (Gcd_busy || Gcd_done) begin
            Gcd_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          state <= WAIT;
        end
        TAKE: begin
          if (!Gcd_done) begin
            Gcd_taken <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (capture) begin
        Res_valid <= 1'b1;
        Res_A     <= Gcd_A;
        Res_B     <= Gcd_B;
        Res_gcd   <= Gcd_result;
        Jobs_done <= Jobs_done + CNTW'(1);
        Gcd_taken <= 1'b1;
        state     <= TAKE;
      end
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Directed bench for gcd_requester with a behavioural subtractive GCD attached
// and a scoreboard of expected results checked at each output handshake.
module tb_gcd_requester;

  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       Job_wr = 1'b0;
  logic [4:0] Job_A = '0;
  logic [4:0] Job_B = '0;
  logic       Job_full;
  logic       Job_ovf;
  logic [4:0] Gcd_A;
  logic [4:0] Gcd_B;
  logic       Gcd_ready;
  logic       Gcd_taken;
  logic       Gcd_busy;
  logic       Gcd_done;
  logic [4:0] Gcd_result;
  logic       Res_valid;
  logic [4:0] Res_A;
  logic [4:0] Res_B;
  logic [4:0] Res_gcd;
  logic       Res_ack = 1'b0;
  logic [7:0] Jobs_done;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] g;
  } exp_t;

  typedef enum logic [1:0] {G_IDLE, G_COMPUTE, G_DONE} gstate_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  gstate_t    g_state;
  logic [4:0] g_a;
  logic [4:0] g_b;
  logic [4:0] g_res;
  logic       prev_ready = 1'b0;
  logic [4:0] prev_a = '0;
  logic [4:0] prev_b = '0;

  always #5 Clk = ~Clk;

  gcd_requester #(.WIDTH(5), .DEPTH(4), .CNTW(8)) dut (
    .Clk(Clk), .rst(rst),
    .Job_wr(Job_wr), .Job_A(Job_A), .Job_B(Job_B),
    .Job_full(Job_full), .Job_ovf(Job_ovf),
    .Gcd_A(Gcd_A), .Gcd_B(Gcd_B), .Gcd_ready(Gcd_ready), .Gcd_taken(Gcd_taken),
    .Gcd_busy(Gcd_busy), .Gcd_done(Gcd_done), .Gcd_result(Gcd_result),
    .Res_valid(Res_valid), .Res_A(Res_A), .Res_B(Res_B), .Res_gcd(Res_gcd),
    .Res_ack(Res_ack), .Jobs_done(Jobs_done)
  );

  // Stand-in for the GCD unit, reset together with the requester.
  assign Gcd_busy   = (g_state == G_COMPUTE);
  assign Gcd_done   = (g_state == G_DONE);
  assign Gcd_result = g_res;

  always @(posedge Clk or posedge rst) begin
    if (rst) begin
      g_state <= G_IDLE;
      g_a     <= '0;
      g_b     <= '0;
      g_res   <= '0;
    end else begin
      case (g_state)
        G_IDLE: begin
          if (Gcd_ready) begin
            g_a     <= Gcd_A;
            g_b     <= Gcd_B;
            g_state <= G_COMPUTE;
          end
        end
        G_COMPUTE: begin
          if (g_b == 5'd0 || g_a == g_b) begin
            g_res   <= g_a;
            g_state <= G_DONE;
          end else if (g_a == 5'd0) begin
            g_res   <= g_b;
            g_state <= G_DONE;
          end else if (g_a > g_b) begin
            g_a <= g_a - g_b;
          end else begin
            g_b <= g_b - g_a;
          end
        end
        G_DONE: begin
          if (Gcd_taken) begin
            g_state <= G_IDLE;
          end
        end
        default: g_state <= G_IDLE;
      endcase
    end
  end

  function automatic logic [4:0] gcdRef(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return 5'(x);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] a, input logic [4:0] b, input bit accepted);
    Job_wr = 1'b1;
    Job_A  = a;
    Job_B  = b;
    if (accepted) begin
      sb.push_back('{a: a, b: b, g: gcdRef(int'(a), int'(b))});
    end
    @(negedge Clk);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(negedge Clk);
    end
    checkOutput(tag, sb.size(), 0);
  endtask

  // Samples one time unit before each rising edge, where a valid&ack pair means a transfer.
  always @(negedge Clk) begin
    exp_t e;
    #4;
    if (!rst) begin
      checks++;
      assert (!(Gcd_ready && Gcd_taken)) else begin
        errors++;
        $error("[TB] FAIL ready_taken_overlap observed=%0b%0b expected not both 1", Gcd_ready, Gcd_taken);
      end
      if (prev_ready && Gcd_ready) begin
        checks++;
        assert (Gcd_A === prev_a && Gcd_B === prev_b) else begin
          errors++;
          $error("[TB] FAIL operand_stable observed=%0d,%0d expected=%0d,%0d", Gcd_A, Gcd_B, prev_a, prev_b);
        end
      end
      if (Res_valid && Res_ack) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_result observed=%0d expected no result", Res_gcd);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("res_a", Res_A, e.a);
          checkOutput("res_b", Res_B, e.b);
          checkOutput("res_gcd", Res_gcd, e.g);
        end
      end
      prev_ready = Gcd_ready;
      prev_a     = Gcd_A;
      prev_b     = Gcd_B;
    end else begin
      prev_ready = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] t4a [6];
    logic [4:0] t4b [6];
    bit         found;
    t4a = '{5'd30, 5'd12, 5'd14, 5'd25, 5'd16, 5'd7};
    t4b = '{5'd1,  5'd8,  5'd21, 5'd15, 5'd24, 5'd3};

    // Reset state
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_gcd_ready", Gcd_ready, 0);
    checkOutput("rst_res_valid", Res_valid, 0);
    checkOutput("rst_jobs_done", Jobs_done, 0);
    checkOutput("rst_job_full", Job_full, 0);
    repeat (2) @(negedge Clk);
    rst = 1'b0;

    // Single job with ack high, plus issue latency
    Res_ack = 1'b1;
    @(negedge Clk);
    applyStimulus(5'd6, 5'd3, 1'b1);
    Job_wr = 1'b0;
    checkOutput("ready_after_push_edge", Gcd_ready, 0);
    @(negedge Clk);
    checkOutput("ready_second_edge", Gcd_ready, 1);
    for (int i = 0; i < 20 && !Gcd_busy; i++) @(negedge Clk);
    checkOutput("busy_seen", Gcd_busy, 1);
    checkOutput("ready_while_busy_first", Gcd_ready, 1);
    @(negedge Clk);
    checkOutput("ready_dropped", Gcd_ready, 0);
    waitDrain("drain_t1", 100);
    repeat (5) @(negedge Clk);
    checkOutput("t1_jobs_done", Jobs_done, 1);
    checkOutput("t1_res_valid", Res_valid, 0);

    // Back-to-back jobs
    applyStimulus(5'd2, 5'd7, 1'b1);
    applyStimulus(5'd30, 5'd20, 1'b1);
    applyStimulus(5'd5, 5'd10, 1'b1);
    Job_wr = 1'b0;
    waitDrain("drain_t2", 300);
    repeat (5) @(negedge Clk);
    checkOutput("t2_jobs_done", Jobs_done, 4);
    checkOutput("t2_job_ovf", Job_ovf, 0);

    // Output back-pressure
    Res_ack = 1'b0;
    applyStimulus(5'd3, 5'd21, 1'b1);
    applyStimulus(5'd11, 5'd11, 1'b1);
    Job_wr = 1'b0;
    repeat (60) @(negedge Clk);
    checkOutput("t3_held_valid", Res_valid, 1);
    checkOutput("t3_held_gcd", Res_gcd, 3);
    checkOutput("t3_taken_low", Gcd_taken, 0);
    checkOutput("t3_gcd_in_done", (g_state == G_DONE), 1);
    checkOutput("t3_jobs_done_held", Jobs_done, 5);
    Res_ack = 1'b1;
    @(negedge Clk);
    Res_ack = 1'b0;
    checkOutput("t3_valid_stays", Res_valid, 1);
    checkOutput("t3_new_gcd", Res_gcd, 11);
    checkOutput("t3_new_a", Res_A, 11);
    checkOutput("t3_jobs_done", Jobs_done, 6);
    Res_ack = 1'b1;
    waitDrain("drain_t3", 50);
    repeat (5) @(negedge Clk);

    // Overflow with DEPTH=4
    Res_ack = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(t4a[i], t4b[i], i < 5);
    Job_wr = 1'b0;
    checkOutput("t4_full", Job_full, 1);
    checkOutput("t4_ovf", Job_ovf, 1);
    Res_ack = 1'b1;
    waitDrain("drain_t4", 800);
    repeat (20) @(negedge Clk);
    checkOutput("t4_jobs_done", Jobs_done, 11);
    checkOutput("t4_ovf_sticky", Job_ovf, 1);
    checkOutput("t4_not_full", Job_full, 0);

    // Reset mid-job while waiting on (4,2)
    applyStimulus(5'd28, 5'd0, 1'b1);
    applyStimulus(5'd4, 5'd2, 1'b0);
    Job_wr = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (Gcd_A == 5'd4 && Gcd_B == 5'd2 && Gcd_busy && !Gcd_ready) found = 1'b1;
      else @(negedge Clk);
    end
    checkOutput("t5_wait_reached", found, 1);
    checkOutput("t5_sb_empty", sb.size(), 0);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_gcd_a", Gcd_A, 0);
    checkOutput("t5_rst_gcd_b", Gcd_B, 0);
    checkOutput("t5_rst_jobs_done", Jobs_done, 0);
    checkOutput("t5_rst_ovf", Job_ovf, 0);
    checkOutput("t5_rst_res_gcd", Res_gcd, 0);
    checkOutput("t5_rst_res_a", Res_A, 0);
    checkOutput("t5_rst_taken", Gcd_taken, 0);
    repeat (2) @(negedge Clk);
    rst = 1'b0;
    @(negedge Clk);
    applyStimulus(5'd6, 5'd3, 1'b1);
    Job_wr = 1'b0;
    waitDrain("drain_t5", 100);
    repeat (20) @(negedge Clk);
    checkOutput("t5_jobs_done", Jobs_done, 1);
    checkOutput("t5_res_valid", Res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
